// File: rtl/intersection_if.sv
// Signal bundle between the intersection phase sequencer and its sensors and lamp drivers.
// The controller connects through the master modport.
interface intersection_if;
   logic       side_req;
   logic       ped_req;
   logic       main_red;
   logic       main_ora;
   logic       main_gre;
   logic       side_red;
   logic       side_ora;
   logic       side_gre;
   logic       walk;
   logic [2:0] phase;

   modport master (
      input  side_req, ped_req,
      output main_red, main_ora, main_gre, side_red, side_ora, side_gre, walk, phase
   );

   modport slave (
      output side_req, ped_req,
      input  main_red, main_ora, main_gre, side_red, side_ora, side_gre, walk, phase
   );
endinterface

// File: rtl/intersection_ctrl.sv
// Two-way intersection phase sequencer. Main street rests on green; latched side-street and
// pedestrian requests pull it through orange and all-red clearance into the served phase.
// Optional pedestrian logic is enabled by defining INTERSECTION_PED_EN.
module intersection_ctrl #(
   parameter int unsigned RED_CLR  = 2,
   parameter int unsigned MAIN_GRN = 12,
   parameter int unsigned MAIN_ORA = 3,
   parameter int unsigned SIDE_GRN = 9,
   parameter int unsigned SIDE_ORA = 3,
   parameter int unsigned WALK_T   = 6
) (
   input logic            clk,
   input logic            rst_n,
   intersection_if.master bus
);

   typedef enum logic [2:0] {
      StMainG = 3'd0,
      StMainO = 3'd1,
      StAllR1 = 3'd2,
      StSideG = 3'd3,
      StSideO = 3'd4,
      StAllR2 = 3'd5,
      StWalk  = 3'd6
   } state_e;

   // Last timer value of each phase; the phase ends on the edge that sees it.
   localparam logic [5:0] RedLast     = 6'(RED_CLR - 1);
   localparam logic [5:0] MainGrnLast = 6'(MAIN_GRN - 1);
   localparam logic [5:0] MainOraLast = 6'(MAIN_ORA - 1);
   localparam logic [5:0] SideGrnLast = 6'(SIDE_GRN - 1);
   localparam logic [5:0] SideOraLast = 6'(SIDE_ORA - 1);
   localparam logic [5:0] WalkLast    = 6'(WALK_T - 1);

   // Lamp vector order: {main_red, main_ora, main_gre, side_red, side_ora, side_gre, walk}
   localparam logic [6:0] LampsAllRed = 7'b100_100_0;

   state_e     state_q, state_d;
   logic [5:0] timer_q, timer_d;
   logic       side_pend_q, side_pend_d;
   logic [6:0] lamps_q, lamps_d;
   logic       enter_side;
   logic       ped_pend_q;
   logic       ped_hit;

`ifdef INTERSECTION_PED_EN
   logic ped_pend_d;
   logic enter_walk;

   // A live button press counts at the MAIN_G exit edge, so late requests see no extra delay.
   assign ped_hit    = ped_pend_q | bus.ped_req;
   assign enter_walk = (state_d == StWalk) && (state_q != StWalk);
   assign ped_pend_d = bus.ped_req | (ped_pend_q & ~enter_walk);

   // Pedestrian request latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ped_pend_q <= 1'b0;
      else        ped_pend_q <= ped_pend_d;
   end
`else
   logic       unused_ped_req;
   logic [5:0] unused_walk_last;

   assign ped_pend_q       = 1'b0;
   assign ped_hit          = 1'b0;
   assign unused_ped_req   = bus.ped_req;
   assign unused_walk_last = WalkLast;
`endif

   assign enter_side  = (state_d == StSideG) && (state_q != StSideG);
   // Set wins over clear when a request coincides with the SIDE_G entry edge.
   assign side_pend_d = bus.side_req | (side_pend_q & ~enter_side);

   // Next-state selection; any unused code recovers to all-red clearance.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StMainG: begin
            if (timer_q >= MainGrnLast && (side_pend_q || bus.side_req || ped_hit)) begin
               state_d = StMainO;
            end
         end
         StMainO: if (timer_q == MainOraLast) state_d = StAllR1;
         StAllR1: begin
            if (timer_q == RedLast) state_d = (side_pend_q || !ped_pend_q) ? StSideG : StWalk;
         end
         StSideG: if (timer_q == SideGrnLast) state_d = StSideO;
         StSideO: if (timer_q == SideOraLast) state_d = StAllR2;
         StAllR2: if (timer_q == RedLast) state_d = ped_pend_q ? StWalk : StMainG;
`ifdef INTERSECTION_PED_EN
         StWalk:  if (timer_q == WalkLast) state_d = StMainG;
`endif
         default: state_d = StAllR2;
      endcase
   end

   // Per-state timer: restarts on entry, saturates rather than wrapping.
   always_comb begin
      timer_d = timer_q + 6'd1;
      if (state_d != state_q)    timer_d = '0;
      else if (timer_q == 6'd63) timer_d = timer_q;
   end

   // Lamp pattern for the state being entered, so lamps switch on the same edge as phase.
   always_comb begin
      lamps_d = LampsAllRed;
      case (state_d)
         StMainG: lamps_d = 7'b001_100_0;
         StMainO: lamps_d = 7'b010_100_0;
         StSideG: lamps_d = 7'b100_001_0;
         StSideO: lamps_d = 7'b100_010_0;
`ifdef INTERSECTION_PED_EN
         StWalk:  lamps_d = 7'b100_100_1;
`endif
         default: lamps_d = LampsAllRed;
      endcase
   end

   // State, timer, side latch and lamp registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StAllR2;
         timer_q     <= '0;
         side_pend_q <= 1'b0;
         lamps_q     <= LampsAllRed;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         side_pend_q <= side_pend_d;
         lamps_q     <= lamps_d;
      end
   end

   assign bus.main_red = lamps_q[6];
   assign bus.main_ora = lamps_q[5];
   assign bus.main_gre = lamps_q[4];
   assign bus.side_red = lamps_q[3];
   assign bus.side_ora = lamps_q[2];
   assign bus.side_gre = lamps_q[1];
   assign bus.walk     = lamps_q[0];
   assign bus.phase    = state_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Directed bench for intersection_ctrl with default timing parameters.
// Edge 0 is the last edge with rst_n low; outputs are sampled 1 time unit after each edge.
module tb_intersection_ctrl;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   intersection_if bus ();

   intersection_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {main_red, main_ora, main_gre, side_red, side_ora, side_gre, walk} per phase code.
   function automatic logic [6:0] lamps_of(input logic [2:0] p);
      case (p)
         3'd0:    return 7'b001_100_0;
         3'd1:    return 7'b010_100_0;
         3'd3:    return 7'b100_001_0;
         3'd4:    return 7'b100_010_0;
         3'd6:    return 7'b100_100_1;
         default: return 7'b100_100_0;
      endcase
   endfunction

   // Phase at edge e of a side-street service whose MAIN_O starts at edge base.
   function automatic logic [2:0] side_seq(input int e, input int base);
      int d;
      if (e < 2) return 3'd5;
      if (e < base) return 3'd0;
      d = e - base;
      if (d < 3)  return 3'd1;
      if (d < 5)  return 3'd2;
      if (d < 14) return 3'd3;
      if (d < 17) return 3'd4;
      if (d < 19) return 3'd5;
      return 3'd0;
   endfunction

   function automatic logic [6:0] lamps_now();
      return {bus.main_red, bus.main_ora, bus.main_gre,
              bus.side_red, bus.side_ora, bus.side_gre, bus.walk};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset held over two edges; release follows edge 0.
   task automatic do_reset();
      rst_n        = 1'b0;
      bus.side_req = 1'b0;
      bus.ped_req  = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [2:0] exp_p;
      rst_n        = 1'b0;
      bus.side_req = 1'b0;
      bus.ped_req  = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      total++;
      if (bus.phase !== 3'd5) begin
         bad++;
         $display("FAIL reset_phase got=%0d want=5", bus.phase);
      end
      total++;
      if (lamps_now() !== 7'b100_100_0) begin
         bad++;
         $display("FAIL reset_lamps got=%b want=1001000", lamps_now());
      end
      rst_n = 1'b1;
      for (int e = 1; e <= 100; e++) begin
         tick();
         exp_p = (e < 2) ? 3'd5 : 3'd0;
         total++;
         if (bus.phase !== exp_p) begin
            bad++;
            $display("FAIL idle_phase edge=%0d got=%0d want=%0d", e, bus.phase, exp_p);
         end
         total++;
         if (lamps_now() !== lamps_of(exp_p)) begin
            bad++;
            $display("FAIL idle_lamps edge=%0d got=%b want=%b", e, lamps_now(), lamps_of(exp_p));
         end
      end
   endtask

   task automatic test_side();
      logic [2:0] exp_p;
      do_reset();
      for (int e = 1; e <= 40; e++) begin
         bus.side_req = (e == 5);
         tick();
         exp_p = side_seq(e, 14);
         total++;
         if (bus.phase !== exp_p) begin
            bad++;
            $display("FAIL side_phase edge=%0d got=%0d want=%0d", e, bus.phase, exp_p);
         end
         total++;
         if (lamps_now() !== lamps_of(exp_p)) begin
            bad++;
            $display("FAIL side_lamps edge=%0d got=%b want=%b", e, lamps_now(), lamps_of(exp_p));
         end
      end
      bus.side_req = 1'b0;
   endtask

   task automatic test_ped();
      logic [2:0] exp_p;
      do_reset();
      for (int e = 1; e <= 40; e++) begin
         bus.ped_req = (e == 20);
         tick();
         exp_p = (e < 2) ? 3'd5 : 3'd0;
`ifdef INTERSECTION_PED_EN
         if (e >= 20 && e <= 22) exp_p = 3'd1;
         if (e >= 23 && e <= 24) exp_p = 3'd2;
         if (e >= 25 && e <= 30) exp_p = 3'd6;
`endif
         total++;
         if (bus.phase !== exp_p) begin
            bad++;
            $display("FAIL ped_phase edge=%0d got=%0d want=%0d", e, bus.phase, exp_p);
         end
         total++;
         if (lamps_now() !== lamps_of(exp_p)) begin
            bad++;
            $display("FAIL ped_lamps edge=%0d got=%b want=%b", e, lamps_now(), lamps_of(exp_p));
         end
      end
      bus.ped_req = 1'b0;
   endtask

   task automatic test_both();
      logic [2:0] exp_p;
      do_reset();
      for (int e = 1; e <= 45; e++) begin
         bus.side_req = (e == 3);
         bus.ped_req  = (e == 3);
         tick();
         exp_p = side_seq(e, 14);
`ifdef INTERSECTION_PED_EN
         if (e >= 33 && e <= 38) exp_p = 3'd6;
`endif
         total++;
         if (bus.phase !== exp_p) begin
            bad++;
            $display("FAIL both_phase edge=%0d got=%0d want=%0d", e, bus.phase, exp_p);
         end
         total++;
         if (lamps_now() !== lamps_of(exp_p)) begin
            bad++;
            $display("FAIL both_lamps edge=%0d got=%b want=%b", e, lamps_now(), lamps_of(exp_p));
         end
      end
      bus.side_req = 1'b0;
      bus.ped_req  = 1'b0;
   endtask

   // Request held through the SIDE_G entry edge re-arms the latch for another service.
   task automatic test_side_held();
      logic [2:0] exp_p;
      do_reset();
      for (int e = 1; e <= 66; e++) begin
         bus.side_req = (e >= 5 && e <= 19);
         tick();
         exp_p = (e < 33) ? side_seq(e, 14) : side_seq(e, 45);
         total++;
         if (bus.phase !== exp_p) begin
            bad++;
            $display("FAIL held_phase edge=%0d got=%0d want=%0d", e, bus.phase, exp_p);
         end
         total++;
         if (lamps_now() !== lamps_of(exp_p)) begin
            bad++;
            $display("FAIL held_lamps edge=%0d got=%b want=%b", e, lamps_now(), lamps_of(exp_p));
         end
      end
      bus.side_req = 1'b0;
   endtask

   // Reset mid SIDE_G must act at once and drop the request latched at edge 21.
   task automatic test_mid_reset();
      logic [2:0] exp_p;
      do_reset();
      for (int e = 1; e <= 22; e++) begin
         bus.side_req = (e == 5 || e == 21);
         tick();
      end
      bus.side_req = 1'b0;
      total++;
      if (bus.phase !== 3'd3) begin
         bad++;
         $display("FAIL midrst_pre got=%0d want=3", bus.phase);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.phase !== 3'd5) begin
         bad++;
         $display("FAIL midrst_async_phase got=%0d want=5", bus.phase);
      end
      total++;
      if (lamps_now() !== 7'b100_100_0) begin
         bad++;
         $display("FAIL midrst_async_lamps got=%b want=1001000", lamps_now());
      end
      tick();
      rst_n = 1'b1;
      for (int e = 1; e <= 30; e++) begin
         tick();
         exp_p = (e < 2) ? 3'd5 : 3'd0;
         total++;
         if (bus.phase !== exp_p) begin
            bad++;
            $display("FAIL midrst_phase edge=%0d got=%0d want=%0d", e, bus.phase, exp_p);
         end
         total++;
         if (lamps_now() !== lamps_of(exp_p)) begin
            bad++;
            $display("FAIL midrst_lamps edge=%0d got=%b want=%b", e, lamps_now(), lamps_of(exp_p));
         end
      end
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      rst_n        = 1'b0;
      bus.side_req = 1'b0;
      bus.ped_req  = 1'b0;
      test_reset();
      test_side();
      test_ped();
      test_both();
      test_side_held();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
